// File: rtl/debuger_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// debuger_wr_arbiter_pkg
// Shared definitions for the debug-peripheral write arbiter:
//   - debug peripheral register addresses (UART_TX, TIMER, COTRL, COTRL_COREMARK)
//   - arbiter FSM state encoding
//   - pointer width helper (at least one bit, even for a single requester)
// -----------------------------------------------------------------------------
package debuger_wr_arbiter_pkg;

    localparam logic [31:0] UART_TX_ADDR        = 32'h6000_0000;
    localparam logic [31:0] TIMER_ADDR          = 32'h6000_0004;
    localparam logic [31:0] COTRL_ADDR          = 32'h6000_0008;
    localparam logic [31:0] COTRL_COREMARK_ADDR = 32'h6000_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic int ptr_width(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

endpackage

// File: rtl/debuger_wr_arbiter_rr_arb.sv
// -----------------------------------------------------------------------------
// debuger_wr_arbiter_rr_arb
// Purely combinational round-robin pick: grants the first set request bit at
// or after the pointer, wrapping from NR-1 back to 0.
// Ports:
//   req    in  NR   pending requests
//   ptr    in  PW   highest-priority requester index (must be < NR)
//   grant  out NR   one-hot grant (all zero when no request)
//   idx    out PW   binary index of the granted requester
//   any    out 1    at least one request pending
// -----------------------------------------------------------------------------
module debuger_wr_arbiter_rr_arb #(
    parameter int NR = 2,
    parameter int PW = 1
) (
    input  logic [NR-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NR-1:0] grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    logic          found;

    // Explicit wrap keeps non-power-of-two NR correct: ptr+k is computed one
    // bit wider and folded back by subtracting NR once.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NR; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NR)) begin
                sum = sum - (PW+1)'(NR);
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
        any = found;
    end

endmodule

// File: rtl/debuger_wr_arbiter.sv
// -----------------------------------------------------------------------------
// debuger_wr_arbiter
// Round-robin arbiter serialising single write requests from NR requesters
// onto one AXI-lite write port. One write outstanding at a time; AWID carries
// the granted requester index so BID can be checked against it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; grant, capture payload, pulse REQ_READY
// ADDR    | AW and W channels valid until each is individually accepted
// RESP    | M_BREADY high, waiting for the B response
//
// Ports:
//   CLK, RSTn                     clock, async active-low reset
//   REQ_VALID/ADDR/DATA  in       per-requester write requests (packed slices)
//   REQ_READY            out      one-hot pulse: request accepted (IDLE cycle)
//   REQ_DONE             out      one-hot pulse: B response received
//   ERR                  out      sticky BID mismatch / BRESP error flag
//   M_AW*, M_W*, M_B*             AXI-lite write master port
// -----------------------------------------------------------------------------
module debuger_wr_arbiter
    import debuger_wr_arbiter_pkg::*;
#(
    parameter int NR  = 2,
    parameter int IDW = 4,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NR-1:0]     REQ_VALID,
    input  logic [NR*AW-1:0]  REQ_ADDR,
    input  logic [NR*DW-1:0]  REQ_DATA,
    output logic [NR-1:0]     REQ_READY,
    output logic [NR-1:0]     REQ_DONE,
    output logic              ERR,
    output logic [IDW-1:0]    M_AWID,
    output logic [AW-1:0]     M_AWADDR,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    output logic [DW-1:0]     M_WDATA,
    output logic [DW/8-1:0]   M_WSTRB,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    input  logic [IDW-1:0]    M_BID,
    input  logic [1:0]        M_BRESP,
    input  logic              M_BVALID,
    output logic              M_BREADY
);

    localparam int PW = ptr_width(NR);

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  ptr_q, gidx_q, ptr_next;
    logic [PW-1:0]  arb_idx;
    logic [NR-1:0]  arb_grant, done_q;
    logic           arb_any;
    logic [AW-1:0]  addr_q, sel_addr;
    logic [DW-1:0]  data_q, sel_data;
    logic           awvalid_q, wvalid_q, err_q;
    logic           grant_now, aw_hs, w_hs, aw_ok, w_ok, b_hs;

    debuger_wr_arbiter_rr_arb #(
        .NR (NR),
        .PW (PW)
    ) u_rr_arb (
        .req   (REQ_VALID),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign grant_now = (state_q == ST_IDLE) && arb_any;
    assign aw_hs     = awvalid_q && M_AWREADY;
    assign w_hs      = wvalid_q && M_WREADY;
    // A channel is finished when it was accepted earlier (valid already
    // dropped) or is being accepted in this cycle.
    assign aw_ok     = !awvalid_q || M_AWREADY;
    assign w_ok      = !wvalid_q || M_WREADY;
    assign b_hs      = (state_q == ST_RESP) && M_BVALID;
    assign ptr_next  = (gidx_q == PW'(NR-1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NR; i++) begin
            if (arb_grant[i]) begin
                sel_addr = REQ_ADDR[i*AW +: AW];
                sel_data = REQ_DATA[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (arb_any)        state_d = ST_ADDR;
            ST_ADDR: if (aw_ok && w_ok)  state_d = ST_RESP;
            ST_RESP: if (M_BVALID)       state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            if (grant_now) begin
                gidx_q    <= arb_idx;
                addr_q    <= sel_addr;
                data_q    <= sel_data;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end
            if (state_q == ST_ADDR) begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs)  wvalid_q  <= 1'b0;
            end
            if (b_hs) begin
                done_q[gidx_q] <= 1'b1;
                ptr_q          <= ptr_next;
                if ((M_BID != IDW'(gidx_q)) || (M_BRESP != 2'b00)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // REQ_READY is the live grant in IDLE so the requester sees acceptance in
    // the same cycle its payload is captured.
    assign REQ_READY = grant_now ? arb_grant : '0;
    assign REQ_DONE  = done_q;
    assign ERR       = err_q;
    assign M_AWID    = IDW'(gidx_q);
    assign M_AWADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = data_q;
    assign M_WSTRB   = '1;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = (state_q == ST_RESP);

endmodule
